muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Multi-cycle unsigned multiply/divide execute unit in the RISC datapath.
- Consumes the register file's two read-port operands (A_Data, B_Data).
- Writes its 32-bit result back through the register file's write port (RW, DA, D_Data) after a fixed iteration count.
- Sits between operand read and register write-back, beside the single-cycle ALU.

Parameters:
- WIDTH, 32, operand/result width; the counter is sized to count WIDTH iterations.

Ports:
- CLK  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  2  00 MUL (low product), 01 MULHU (high product), 10 DIVU (quotient), 11 REMU (remainder)
- A_Data  input  WIDTH  operand A / dividend
- B_Data  input  WIDTH  operand B / divisor
- DA_in  input  5  destination register for the result
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle completion pulse
- RW  output  1  register-file write enable
- DA  output  5  destination register, captured at start
- D_Data  output  WIDTH  result

Behaviour:
- Reset (reset=0, asynchronous, any state):
  - state=IDLE, counter=0, all internal registers cleared.
  - busy=0, done=0, RW=0, DA=0, D_Data=0.
  - Any in-flight operation is discarded and no write is issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at a clock edge: capture A_Data, B_Data, op, DA_in; clear the accumulator, counter=0; go to RUN.
  - If start=0: stay in IDLE.
- RUN:
  - One iteration per clock; counter increments.
  - After the WIDTH-th iteration (counter reaches WIDTH-1 and iterates), go to DONE.
- DONE:
  - Lasts exactly one cycle; done=1 for that cycle; next edge returns to IDLE.
- Latency: start sampled at edge 0, so done is high in the cycle between edge 32 and edge 33 (WIDTH=32). Fixed for all ops and operand values.
- Multiply:
  - Shift-add into a 2*WIDTH product register.
  - Each iteration: if the multiplier LSB is 1, add the multiplicand to the upper half; then shift right 1, with the carry entering the MSB.
  - MUL returns product[WIDTH-1:0]; MULHU returns product[2*WIDTH-1:WIDTH].
- Divide:
  - Restoring division with a WIDTH+1-bit partial remainder.
  - Each iteration: shift {rem, quot} left 1; trial-subtract the divisor; if the result is non-negative, keep it and set quot LSB=1; otherwise restore.
  - DIVU returns quot; REMU returns rem[WIDTH-1:0].
- Divide by zero (B=0): no special path and no exception.
  - DIVU result = all ones (0xFFFFFFFF).
  - REMU result = dividend.
  - Latency is unchanged.
- Write-back:
  - D_Data and DA are registered and become valid in the same cycle as done; they hold until the next accepted start.
  - RW = done AND (DA != 0), so a result for register 0 is never written.
- start while busy=1 (RUN or DONE) is ignored; captured operands are unaffected. A new start is accepted no earlier than the IDLE cycle after DONE.
- Input changes on A_Data/B_Data/op/DA_in after capture have no effect.
- Reset deasserting: the first edge after reset returns high may accept start normally.

Test Plan:
- MUL, A=7, B=6, DA_in=3: start at edge 0 → done=1, RW=1, DA=3, D_Data=42 in the cycle after edge 32; busy falls after edge 33.
- MULHU, A=0xFFFFFFFF, B=0xFFFFFFFF → D_Data=0xFFFFFFFE. MUL on the same operands → D_Data=0x00000001.
- DIVU 100/7 → D_Data=14. REMU 100/7 → D_Data=2. DIVU 5/9 → 0. REMU 5/9 → 5.
- Divide by zero, A=0x1234, B=0: DIVU → 0xFFFFFFFF; REMU → 0x1234; both with the standard 33-edge latency.
- start pulsed at edge 10 of a running MUL with different operands and DA_in → ignored; original result and DA emitted; exactly one done pulse. DA_in=0 → done pulses but RW stays 0.
- reset=0 asserted mid-RUN (edge 15) → busy/done/RW/D_Data go to 0 immediately without a clock. After release, no done pulse appears; a fresh start completes correctly.

Source files
------------

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle unsigned multiply/divide unit with register-file write-back
// Shift-add multiply and restoring divide share one accumulator/low-word datapath.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A_Data,
   input  logic [WIDTH-1:0] B_Data,
   input  logic [4:0]       DA_in,
   output logic             busy,
   output logic             done,
   output logic             RW,
   output logic [4:0]       DA,
   output logic [WIDTH-1:0] D_Data
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [1:0]       state;
   logic [CW-1:0]    count;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] opnd;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] lo;

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] acc_n;
   logic [WIDTH-1:0] lo_n;
   logic [WIDTH-1:0] result;

   // Multiply: {acc, lo} is the product, lo starts as the multiplier.
   // Divide: acc is the partial remainder, lo shifts the dividend out and the quotient in.
   always_comb begin
      sum     = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
      shifted = {acc, lo[WIDTH-1]};
      diff    = shifted - {1'b0, opnd};
      if (!op_q[1]) begin
         acc_n = sum[WIDTH:1];
         lo_n  = {sum[0], lo[WIDTH-1:1]};
      end else if (!diff[WIDTH]) begin
         acc_n = diff[WIDTH-1:0];
         lo_n  = {lo[WIDTH-2:0], 1'b1};
      end else begin
         acc_n = shifted[WIDTH-1:0];
         lo_n  = {lo[WIDTH-2:0], 1'b0};
      end
      result = op_q[0] ? acc_n : lo_n;
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state  <= S_IDLE;
         count  <= '0;
         op_q   <= '0;
         opnd   <= '0;
         acc    <= '0;
         lo     <= '0;
         DA     <= '0;
         D_Data <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  op_q  <= op;
                  opnd  <= op[1] ? B_Data : A_Data;
                  lo    <= op[1] ? A_Data : B_Data;
                  acc   <= '0;
                  count <= '0;
                  DA    <= DA_in;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               acc   <= acc_n;
               lo    <= lo_n;
               count <= count + 1'b1;
               if (count == LAST) begin
                  D_Data <= result;
                  state  <= S_DONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);
   assign RW   = done && (DA != 5'd0);

endmodule
